quire_stream_arbiter: RTL and testbench

- Shares one quire accumulator (4-bit posit, es=0, 19-bit quire) between NUM_REQ upstream product streams.
- Sits between the posit multipliers and the quire, and between the quire and the result consumer.
- Grants the quire to one requester per accumulation window (sow..eow) in round-robin order.
- Keeps a FIFO of window owner IDs, drops the quire's intermediate beats, and forwards only each window's final (eow) result, tagged with its owner ID.

---
 rtl/quire_stream_arbiter.sv | 167 ++++++++++++++++
 tb/tb_quire_stream_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quire_stream_arbiter.sv
// Shares one quire between NUM_REQ product streams: round-robin grant per sow..eow window,
// and forwards only each window's final (eow) quire result tagged with its owner ID.
module quire_stream_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   rts_i,
  output logic [NUM_REQ-1:0]   rtr_o,
  input  logic [NUM_REQ-1:0]   sow_i,
  input  logic [NUM_REQ-1:0]   eow_i,
  input  logic [4*NUM_REQ-1:0] fraction_i,
  input  logic [4*NUM_REQ-1:0] scale_i,
  input  logic [NUM_REQ-1:0]   sign_i,
  input  logic [NUM_REQ-1:0]   zero_i,
  input  logic [NUM_REQ-1:0]   NaR_i,
  output logic                 q_rts_o,
  input  logic                 q_rtr_i,
  output logic                 q_sow_o,
  output logic                 q_eow_o,
  output logic                 q_sign_o,
  output logic                 q_zero_o,
  output logic                 q_NaR_o,
  output logic [3:0]           q_fraction_o,
  output logic [3:0]           q_scale_o,
  input  logic                 q_rts_i,
  output logic                 q_rtr_o,
  input  logic                 q_sow_i,
  input  logic                 q_eow_i,
  input  logic                 q_NaR_i,
  input  logic [18:0]          q_data_i,
  output logic                 res_rts_o,
  input  logic                 res_rtr_i,
  output logic [18:0]          res_data_o,
  output logic                 res_NaR_o,
  output logic [ID_W-1:0]      res_id_o,
  output logic                 err_o
);
  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  tag_mem_q [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             err_q;

  logic [NUM_REQ-1:0] cand;
  logic [3:0]         frac_arr  [NUM_REQ];
  logic [3:0]         scale_arr [NUM_REQ];
  logic               hit;
  logic [ID_W-1:0]    hit_id;
  logic [ID_W:0]      idx;
  logic               push, pop, fifo_full, fifo_empty, beat_fire, res_fire;
  logic               unused_inputs;

  // The quire's sow flag carries no information the result path needs.
  assign unused_inputs = q_sow_i;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign cand[gi]      = rts_i[gi] & sow_i[gi];
      assign frac_arr[gi]  = fraction_i[4*gi +: 4];
      assign scale_arr[gi] = scale_i[4*gi +: 4];
      assign rtr_o[gi]     = (state_q == LOCKED) && (gnt_id_q == ID_W'(gi)) && q_rtr_i;
    end
  endgenerate

  // First requester with a sow head beat, searching upward from rr_ptr with wrap.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!hit && cand[idx[ID_W-1:0]]) begin
        hit    = 1'b1;
        hit_id = idx[ID_W-1:0];
      end
    end
  end

  assign fifo_full  = (count_q == (PTR_W+1)'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign q_rts_o      = (state_q == LOCKED) & rts_i[gnt_id_q];
  assign q_sow_o      = sow_i[gnt_id_q];
  assign q_eow_o      = eow_i[gnt_id_q];
  assign q_sign_o     = sign_i[gnt_id_q];
  assign q_zero_o     = zero_i[gnt_id_q];
  assign q_NaR_o      = NaR_i[gnt_id_q];
  assign q_fraction_o = frac_arr[gnt_id_q];
  assign q_scale_o    = scale_arr[gnt_id_q];
  assign beat_fire    = q_rts_o & q_rtr_i;

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    push     = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit && !fifo_full) begin
          push     = 1'b1;
          gnt_id_d = hit_id;
          rr_ptr_d = (hit_id == ID_W'(NUM_REQ-1)) ? '0 : hit_id + 1'b1;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (beat_fire && q_eow_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Intermediate quire beats are always accepted and dropped; only eow beats see backpressure.
  assign q_rtr_o    = q_eow_i ? res_rtr_i : 1'b1;
  assign res_rts_o  = q_eow_i & q_rts_i;
  assign res_data_o = q_data_i;
  assign res_NaR_o  = q_NaR_i;
  assign res_id_o   = fifo_empty ? '0 : tag_mem_q[rd_ptr_q];
  assign res_fire   = res_rts_o & res_rtr_i;
  assign pop        = res_fire & !fifo_empty;
  assign err_o      = err_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (res_fire && fifo_empty) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset: the count and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= hit_id;
  end
endmodule

// File: tb/tb_quire_stream_arbiter.sv
// Bench for quire_stream_arbiter: a stand-in quire, queue-driven sources, and a
// transaction-level model checked against the DUT every cycle.
module tb_quire_stream_arbiter;
  localparam int N   = 4;
  localparam int TD  = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   rts_i = '0, sow_i = '0, eow_i = '0, sign_i = '0, zero_i = '0, nar_i = '0;
  logic [4*N-1:0] fraction_i = '0, scale_i = '0;
  logic [N-1:0]   rtr_o;
  logic           q_rts_o, q_rtr_i, q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_NaR_o;
  logic [3:0]     q_fraction_o, q_scale_o;
  logic           q_rts_i, q_rtr_o, q_sow_i, q_eow_i, q_NaR_i;
  logic [18:0]    q_data_i, res_data_o;
  logic           res_rts_o, res_NaR_o, err_o;
  logic           res_rtr_i = 1'b1;
  logic [IDW-1:0] res_id_o;
  logic           inject = 1'b0;

  quire_stream_arbiter #(.NUM_REQ(N), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .rts_i(rts_i), .rtr_o(rtr_o), .sow_i(sow_i), .eow_i(eow_i),
    .fraction_i(fraction_i), .scale_i(scale_i),
    .sign_i(sign_i), .zero_i(zero_i), .NaR_i(nar_i),
    .q_rts_o(q_rts_o), .q_rtr_i(q_rtr_i),
    .q_sow_o(q_sow_o), .q_eow_o(q_eow_o), .q_sign_o(q_sign_o), .q_zero_o(q_zero_o), .q_NaR_o(q_NaR_o),
    .q_fraction_o(q_fraction_o), .q_scale_o(q_scale_o),
    .q_rts_i(q_rts_i), .q_rtr_o(q_rtr_o), .q_sow_i(q_sow_i), .q_eow_i(q_eow_i), .q_NaR_i(q_NaR_i),
    .q_data_i(q_data_i),
    .res_rts_o(res_rts_o), .res_rtr_i(res_rtr_i), .res_data_o(res_data_o),
    .res_NaR_o(res_NaR_o), .res_id_o(res_id_o), .err_o(err_o)
  );

  // Product value in quire units: (1 + frac/16) * 2^scale scaled by 256.
  function automatic logic [18:0] beat_val(logic sg, logic zr, logic nr, logic [3:0] fr, logic [3:0] sc);
    logic [18:0] mag;
    int sh;
    if (zr || nr) return '0;
    sh = int'($signed(sc)) + 4;
    if (sh < 0) sh = 0;
    mag = 19'(16 + int'(fr)) << sh;
    return sg ? -mag : mag;
  endfunction

  // Stand-in quire: running sum per window, 8-deep output buffer.
  typedef struct packed {logic sow; logic eow; logic nar; logic [18:0] data;} qbeat_t;
  qbeat_t      qmem [8];
  logic [2:0]  qwp, qrp;
  logic [3:0]  qcnt;
  logic [18:0] acc;
  logic        acc_nar;
  logic        qtake, qpop;

  assign q_rtr_i  = (qcnt < 4'd8);
  assign q_rts_i  = (qcnt != 0);
  assign q_sow_i  = q_rts_i & qmem[qrp].sow;
  assign q_eow_i  = q_rts_i & qmem[qrp].eow;
  assign q_NaR_i  = qmem[qrp].nar;
  assign q_data_i = qmem[qrp].data;
  assign qtake    = q_rts_o & q_rtr_i;
  assign qpop     = q_rts_i & q_rtr_o;

  always @(posedge clk or posedge rst) begin
    logic [18:0] nacc;
    logic        nnar;
    if (rst) begin
      qwp <= '0; qrp <= '0; qcnt <= '0; acc <= '0; acc_nar <= 1'b0;
    end else begin
      nacc = (q_sow_o ? 19'd0 : acc) + beat_val(q_sign_o, q_zero_o, q_NaR_o, q_fraction_o, q_scale_o);
      nnar = (q_sow_o ? 1'b0 : acc_nar) | q_NaR_o;
      if (qtake) begin
        qmem[qwp] <= '{sow: q_sow_o, eow: q_eow_o, nar: nnar, data: nacc};
        acc <= nacc; acc_nar <= nnar;
      end else if (inject) begin
        qmem[qwp] <= '{sow: 1'b1, eow: 1'b1, nar: 1'b0, data: 19'h12345};
      end
      if (qtake || inject) qwp <= qwp + 1'b1;
      if (qpop) qrp <= qrp + 1'b1;
      qcnt <= qcnt + 4'((qtake || inject) ? 1 : 0) - 4'(qpop ? 1 : 0);
    end
  end

  // Sources: each requester streams its queued beats, advancing on a transfer.
  typedef struct packed {logic sow; logic eow; logic sign; logic zero; logic nar; logic [3:0] frac; logic [3:0] scale;} beat_t;
  beat_t      src_q [N][$];
  logic [N-1:0] fire = '0;

  always @(posedge clk) begin
    beat_t b;
    #2;
    for (int k = 0; k < N; k++) begin
      if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      if (src_q[k].size() > 0) b = src_q[k][0];
      else b = '0;
      rts_i[k] = (src_q[k].size() > 0);
      sow_i[k] = b.sow; eow_i[k] = b.eow; sign_i[k] = b.sign; zero_i[k] = b.zero; nar_i[k] = b.nar;
      fraction_i[4*k +: 4] = b.frac;
      scale_i[4*k +: 4]    = b.scale;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: owner, round-robin pointer and tag list as plain ints/queues.
  typedef struct {logic [18:0] data; logic nar;} res_t;
  bit   m_locked, m_err;
  int   m_owner, m_rr;
  int   m_tags[$];
  res_t m_exp[$];
  logic [18:0] m_sum;
  logic m_nar;
  int   grant_log[$], res_id_log[$];
  int   res_cnt = 0, drop_cnt = 0;
  logic [18:0] last_data;
  logic last_nar;

  always @(negedge clk) begin
    logic qe, exp_qrtr_o, qrtr_i, exp_res_rts, exp_qrts, was_locked;
    logic [N-1:0] exp_rtr;
    int pre, k;
    beat_t b;
    if (rst) begin
      m_locked = 0; m_err = 0; m_owner = 0; m_rr = 0; m_sum = '0; m_nar = 0;
      m_tags.delete(); m_exp.delete(); fire = '0;
    end else begin
      qe          = (qcnt != 0) && qmem[qrp].eow;
      exp_qrtr_o  = qe ? res_rtr_i : 1'b1;
      exp_res_rts = qe;
      qrtr_i      = (qcnt < 4'd8);
      exp_qrts    = m_locked ? rts_i[m_owner] : 1'b0;
      exp_rtr     = '0;
      if (m_locked && qrtr_i) exp_rtr[m_owner] = 1'b1;
      chk("rtr_o", 32'(rtr_o), 32'(exp_rtr));
      chk("q_rts_o", 32'(q_rts_o), 32'(exp_qrts));
      chk("q_rtr_o", 32'(q_rtr_o), 32'(exp_qrtr_o));
      chk("res_rts_o", 32'(res_rts_o), 32'(exp_res_rts));
      chk("err_o", 32'(err_o), 32'(m_err));
      if (exp_qrts) begin
        b = src_q[m_owner][0];
        chk("q_beat", 32'({q_sow_o, q_eow_o, q_sign_o, q_zero_o, q_NaR_o, q_fraction_o, q_scale_o}),
            32'({b.sow, b.eow, b.sign, b.zero, b.nar, b.frac, b.scale}));
      end
      if (exp_res_rts) begin
        chk("res_id_o", 32'(res_id_o), (m_tags.size() > 0) ? 32'(m_tags[0]) : 32'd0);
        if (m_exp.size() > 0) begin
          chk("res_data_o", 32'(res_data_o), 32'(m_exp[0].data));
          chk("res_NaR_o", 32'(res_NaR_o), 32'(m_exp[0].nar));
        end else begin
          chk("unexpected_result", 32'd1, 32'd0);
        end
      end
      fire       = rts_i & rtr_o;
      pre        = m_tags.size();
      was_locked = m_locked;
      if (exp_res_rts && res_rtr_i) begin
        res_cnt++;
        res_id_log.push_back(int'(res_id_o));
        last_data = res_data_o;
        last_nar  = res_NaR_o;
        if (pre == 0) m_err = 1;
        else void'(m_tags.pop_front());
        if (m_exp.size() > 0) void'(m_exp.pop_front());
      end
      if ((qcnt != 0) && !qe) drop_cnt++;
      if (was_locked && exp_qrts && qrtr_i) begin
        b = src_q[m_owner][0];
        m_sum = (b.sow ? 19'd0 : m_sum) + beat_val(b.sign, b.zero, b.nar, b.frac, b.scale);
        m_nar = (b.sow ? 1'b0 : m_nar) | b.nar;
        if (b.eow) begin
          m_exp.push_back('{data: m_sum, nar: m_nar});
          m_locked = 0;
        end
      end else if (!was_locked && pre < TD) begin
        for (int i = 0; i < N; i++) begin
          k = (m_rr + i) % N;
          if (!m_locked && rts_i[k] && sow_i[k]) begin
            m_locked = 1; m_owner = k; m_rr = (k + 1) % N;
            m_tags.push_back(k); grant_log.push_back(k);
          end
        end
      end
    end
  end

  task automatic add_window(int k, int n, bit nar, logic [3:0] frac);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = '0;
      b.sow = (i == 0); b.eow = (i == n - 1); b.nar = nar; b.frac = frac;
      src_q[k].push_back(b);
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (n < budget && !(src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                           src_q[3].size() == 0 && !m_locked && qcnt == 0 && m_exp.size() == 0)) begin
      @(posedge clk); n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required<%0d", n, budget);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < N; k++) src_q[k].delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int gb, rb, rc, dc, n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rtr_o", 32'(rtr_o), 32'd0);
    chk("reset_q_rts_o", 32'(q_rts_o), 32'd0);
    chk("reset_res_rts_o", 32'(res_rts_o), 32'd0);
    chk("reset_err_o", 32'(err_o), 32'd0);
    rst = 1'b0;

    // Single requester, three 1.0 beats -> one 3.0 result, two dropped beats.
    rc = res_cnt; dc = drop_cnt; rb = res_id_log.size();
    add_window(0, 3, 0, 4'd0);
    drain(60);
    chk("t1_results", 32'(res_cnt - rc), 32'd1);
    chk("t1_dropped", 32'(drop_cnt - dc), 32'd2);
    chk("t1_id", 32'(res_id_log[rb]), 32'd0);
    chk("t1_data", 32'(last_data), 32'h300);
    $display("t1 single window: id=%0d data=%0h", res_id_log[rb], last_data);

    // All four requesters at once from reset.
    do_reset();
    gb = grant_log.size(); rb = res_id_log.size();
    for (int k = 0; k < N; k++) add_window(k, 2, 0, 4'(3 * k));
    drain(100);
    for (int k = 0; k < N; k++) begin
      chk("t2_grant", 32'(grant_log[gb + k]), 32'(k));
      chk("t2_res_id", 32'(res_id_log[rb + k]), 32'(k));
    end
    $display("t2 four-way: grants %0d %0d %0d %0d", grant_log[gb], grant_log[gb+1], grant_log[gb+2], grant_log[gb+3]);

    // Requester 2 alone, then 1 and 3 together: 3 wins.
    add_window(2, 2, 0, 4'd5);
    drain(60);
    gb = grant_log.size();
    add_window(1, 1, 0, 4'd1);
    add_window(3, 1, 0, 4'd2);
    drain(60);
    chk("t3_first", 32'(grant_log[gb]), 32'd3);
    chk("t3_second", 32'(grant_log[gb + 1]), 32'd1);
    $display("t3 rr order: %0d then %0d", grant_log[gb], grant_log[gb+1]);

    // Result backpressure across TAG_DEPTH+2 windows.
    do_reset();
    gb = grant_log.size(); rb = res_id_log.size();
    res_rtr_i = 1'b0;
    add_window(0, 1, 0, 4'd1); add_window(0, 1, 0, 4'd2);
    add_window(1, 1, 0, 4'd3); add_window(1, 1, 0, 4'd4);
    add_window(2, 1, 0, 4'd5); add_window(3, 1, 0, 4'd6);
    repeat (40) @(posedge clk);
    #1;
    chk("t4_stalled_grants", 32'(grant_log.size() - gb), 32'(TD));
    res_rtr_i = 1'b1;
    drain(100);
    chk("t4_total_grants", 32'(grant_log.size() - gb), 32'(TD + 2));
    chk("t4_id0", 32'(res_id_log[rb]), 32'd0);
    chk("t4_id1", 32'(res_id_log[rb + 1]), 32'd1);
    chk("t4_id2", 32'(res_id_log[rb + 2]), 32'd2);
    chk("t4_id3", 32'(res_id_log[rb + 3]), 32'd3);
    chk("t4_id4", 32'(res_id_log[rb + 4]), 32'd0);
    chk("t4_id5", 32'(res_id_log[rb + 5]), 32'd1);
    $display("t4 backpressure: %0d results drained", res_id_log.size() - rb);

    // Single-beat NaR window on requester 2.
    rb = res_id_log.size();
    add_window(2, 1, 1, 4'd7);
    drain(40);
    chk("t5_id", 32'(res_id_log[rb]), 32'd2);
    chk("t5_nar", 32'(last_nar), 32'd1);
    $display("t5 single-beat NaR: id=%0d nar=%0d", res_id_log[rb], last_nar);

    // Reset in the middle of a locked window.
    add_window(3, 6, 0, 4'd1);
    n = 0;
    while (n < 20 && q_rts_o !== 1'b1) begin @(posedge clk); #1; n++; end
    chk("t6_locked_seen", 32'(q_rts_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < N; k++) src_q[k].delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t6_rtr_o", 32'(rtr_o), 32'd0);
    chk("t6_q_rts_o", 32'(q_rts_o), 32'd0);
    chk("t6_err_o", 32'(err_o), 32'd0);
    chk("t6_res_rts_o", 32'(res_rts_o), 32'd0);
    gb = grant_log.size();
    add_window(2, 1, 0, 4'd3);
    add_window(0, 1, 0, 4'd3);
    drain(40);
    chk("t6_first_grant", 32'(grant_log[gb]), 32'd0);
    $display("t6 mid-window reset: next grant %0d", grant_log[gb]);

    // Orphan eow result with an empty tag FIFO.
    rb = res_id_log.size();
    m_exp.push_back('{data: 19'h12345, nar: 1'b0});
    @(posedge clk); #1 inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
    drain(20);
    chk("t7_err_o", 32'(err_o), 32'd1);
    chk("t7_id", 32'(res_id_log[rb]), 32'd0);
    chk("t7_data", 32'(last_data), 32'h12345);
    $display("t7 orphan result: id=%0d err=%0d", res_id_log[rb], err_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
